// File: rtl/dmem_window_ctrl.sv
// Data-memory window controller: single-cycle writes, fixed-latency reads, offset range check.
// Optional even-parity array enabled by defining DMEM_PARITY_EN.
//
// state | meaning
// IDLE  | requests sampled each rising edge
// WAIT  | read in flight, cnt_q counts down to completion
module dmem_window_ctrl #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CS,
    input  logic              iWE,
    input  logic [31:0]       iAddress,
    input  logic              RE,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataValid,
    output logic              stall,
    output logic              addrErr,
    output logic              parErr
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] dataOut_q, dataOut_d;
    logic              dataValid_q, dataValid_d;
    logic              stall_q, stall_d;
    logic              addrErr_q, addrErr_d;
    logic              parErr_q, parErr_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic              rd_par_err;
    logic              in_range;
    logic              wr_en;

    assign idx      = iAddress[IDX_W-1:0];
    assign in_range = iAddress < 32'(DEPTH);
    assign wr_en    = (state_q == IDLE) && CS && in_range && iWE;
    assign rd_idx   = (state_q == WAIT) ? idx_q : idx;
    assign rd_word  = mem[rd_idx];

    // RAM is not reset; writes are suppressed while reset is asserted.
    always_ff @(posedge CLK) begin
        if (wr_en && RST) begin
            mem[idx] <= dataIn;
        end
    end

`ifdef DMEM_PARITY_EN
    logic [DEPTH-1:0] par_mem;

    always_ff @(posedge CLK) begin
        if (wr_en && RST) begin
            par_mem[idx] <= ^dataIn;
        end
    end

    assign rd_par_err = (^rd_word) != par_mem[rd_idx];
`else
    assign rd_par_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        dataOut_d   = dataOut_q;
        dataValid_d = 1'b0;
        stall_d     = stall_q;
        addrErr_d   = 1'b0;
        parErr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (CS) begin
                    if (!in_range) begin
                        addrErr_d = 1'b1;
                    end else if (!iWE && RE) begin
                        if (READ_LAT == 1) begin
                            dataOut_d   = rd_word;
                            dataValid_d = 1'b1;
                            parErr_d    = rd_par_err;
                        end else begin
                            idx_d   = idx;
                            cnt_d   = CNT_W'(READ_LAT - 1);
                            stall_d = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d       = '0;
                    dataOut_d   = rd_word;
                    dataValid_d = 1'b1;
                    parErr_d    = rd_par_err;
                    stall_d     = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            stall_q     <= 1'b0;
            addrErr_q   <= 1'b0;
            parErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            stall_q     <= stall_d;
            addrErr_q   <= addrErr_d;
            parErr_q    <= parErr_d;
        end
    end

    assign dataOut   = dataOut_q;
    assign dataValid = dataValid_q;
    assign stall     = stall_q;
    assign addrErr   = addrErr_q;
    assign parErr    = parErr_q;

endmodule

// File: tb/tb_dmem_window_ctrl.sv
// Scoreboard bench for dmem_window_ctrl: directed cases then randomized accesses.
// Parity corruption case is built only when DMEM_PARITY_EN is defined.
module tb_dmem_window_ctrl;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 1024;
    localparam int READ_LAT = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              CS = 1'b0;
    logic              iWE = 1'b0;
    logic [31:0]       iAddress = '0;
    logic              RE = 1'b0;
    logic [DATA_W-1:0] dataIn = '0;
    logic [DATA_W-1:0] dataOut;
    logic              dataValid;
    logic              stall;
    logic              addrErr;
    logic              parErr;

    dmem_window_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
        .CLK(CLK), .RST(RST), .CS(CS), .iWE(iWE), .iAddress(iAddress), .RE(RE),
        .dataIn(dataIn), .dataOut(dataOut), .dataValid(dataValid), .stall(stall),
        .addrErr(addrErr), .parErr(parErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic        par;
        int          cyc;
    } exp_t;

    exp_t        rd_q[$];
    int          err_q[$];
    logic [31:0] model_mem [DEPTH];
    bit          written [DEPTH];
    bit          bad_par [DEPTH];
    int          wlist[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge CLK) begin
        exp_t e;
        if (dataValid) begin
            if (rd_q.size() == 0) begin
                check("unexpected_dataValid", 1, 0);
            end else begin
                e = rd_q.pop_front();
                check("read_data", dataOut, e.data);
                check("read_cycle", cyc, e.cyc);
                check("read_parErr", parErr, e.par);
            end
        end else begin
            if (parErr) check("parErr_without_valid", 1, 0);
            if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                e = rd_q.pop_front();
                check("missing_dataValid", 0, 1);
            end
        end
        if (addrErr) begin
            if (err_q.size() == 0) check("unexpected_addrErr", 1, 0);
            else check("addrErr_cycle", cyc, err_q.pop_front());
        end else if (err_q.size() > 0 && err_q[0] < cyc) begin
            void'(err_q.pop_front());
            check("missing_addrErr", 0, 1);
        end
    end

    task automatic drive_idle();
        CS = 1'b0; iWE = 1'b0; RE = 1'b0; iAddress = '0; dataIn = $urandom;
    endtask

    // One request at the next edge; the model applies the priority rules directly.
    task automatic access(input bit cs, input bit we, input bit re,
                          input logic [31:0] a, input logic [31:0] d);
        bit is_read;
        int i;
        exp_t e;
        is_read = 0;
        i = int'(a % DEPTH);
        if (cs) begin
            if (a >= DEPTH) begin
                err_q.push_back(cyc + 1);
            end else if (we) begin
                model_mem[i] = d;
                bad_par[i] = 0;
                if (!written[i]) begin
                    written[i] = 1;
                    wlist.push_back(i);
                end
            end else if (re) begin
                is_read = 1;
                e.data = model_mem[i];
                e.par  = bad_par[i];
                e.cyc  = cyc + READ_LAT;
                rd_q.push_back(e);
            end
        end
        CS = cs; iWE = we; RE = re; iAddress = a; dataIn = d;
        @(posedge CLK); #1;
        if (is_read) begin
            for (int k = 0; k < READ_LAT - 1; k++) begin
                check("stall_during_read", stall, 1);
                @(posedge CLK); #1;
            end
        end
        drive_idle();
        if (is_read) check("stall_after_read", stall, 0);
    endtask

    initial begin
        int r;
        int a;
        drive_idle();
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        check("rst_dataOut", dataOut, 0);
        check("rst_dataValid", dataValid, 0);
        check("rst_stall", stall, 0);
        check("rst_addrErr", addrErr, 0);
        check("rst_parErr", parErr, 0);
        @(posedge CLK); #1;

        access(1, 0, 0, 0, 0);
        access(1, 1, 0, 32'h000, 32'h1111_1111);
        access(1, 1, 0, 32'h005, 32'hDEAD_BEEF);
        access(1, 0, 1, 32'h005, 32'h0);
        access(1, 1, 0, 32'h400, 32'h0000_0001);
        access(1, 1, 0, 32'h3FF, 32'hA5A5_A5A5);
        access(1, 0, 1, 32'h3FF, 32'h0);
        access(1, 0, 1, 32'h000, 32'h0);
        access(0, 1, 1, 32'h000, 32'h2222_2222);
        access(1, 0, 1, 32'h000, 32'h0);
        access(1, 1, 1, 32'h007, 32'h7777_0007);
        access(1, 0, 1, 32'h007, 32'h0);
        access(1, 1, 0, 32'h020, 32'h0BAD_F00D);
        access(1, 0, 1, 32'h020, 32'h0);
        access(1, 0, 1, 32'h020, 32'h0);

        // Reset while a read is in flight: response is abandoned, nothing pushed.
        CS = 1'b1; iWE = 1'b0; RE = 1'b1; iAddress = 32'h005;
        @(posedge CLK); #1;
        check("midread_stall_before_rst", stall, 1);
        RST = 1'b0;
        #1;
        check("midread_stall_in_rst", stall, 0);
        check("midread_valid_in_rst", dataValid, 0);
        drive_idle();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        access(1, 0, 1, 32'h005, 32'h0);

`ifdef DMEM_PARITY_EN
        access(1, 1, 0, 32'h010, 32'h0000_000F);
        dut.par_mem[16] = ~dut.par_mem[16];
        bad_par[16] = 1;
        access(1, 0, 1, 32'h010, 32'h0);
`endif

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: access(1, 1, 1'($urandom_range(0, 1)),
                                   32'($urandom_range(0, DEPTH - 1)), $urandom);
                4, 5, 6: begin
                    a = wlist[$urandom_range(0, wlist.size() - 1)];
                    access(1, 0, 1, 32'(a), $urandom);
                end
                7: access(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom | 32'h0000_0400, $urandom);
                8: access(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, DEPTH - 1)), $urandom);
                default: begin
                    @(posedge CLK); #1;
                end
            endcase
        end

        repeat (20) @(posedge CLK);
        #1;
        check("scoreboard_reads_drained", rd_q.size(), 0);
        check("scoreboard_errs_drained", err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (tests %0d failed %0d)", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
